// File: rtl/chan_rr_sched.sv
// chan_rr_sched: round-robin owner of the shared demux->mux channel.
// Drives sel1/en_o/sel2 and checks the loop readback for errors.
module chan_rr_sched #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [7:0] dst,
  input  logic       loop_in,
  output logic [3:0] grant,
  output logic       en_o,
  output logic [1:0] sel1,
  output logic [1:0] sel2,
  output logic       chk_valid,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(MAX_BURST - 1);

  state_t     state;
  logic [1:0] last_grant;
  logic [3:0] cnt;
  logic [1:0] win;
  logic       win_ok;
  logic [1:0] idx;

  // Winner search: first set req bit starting just after last owner.
  always_comb begin
    win    = last_grant;
    win_ok = 1'b0;
    idx    = last_grant;
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant + 2'(k);
      if (!win_ok && req[idx]) begin
        win    = idx;
        win_ok = 1'b1;
      end
    end
  end

  // FSM, registered channel controls and readback checker.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= 4'b0000;
      en_o       <= 1'b0;
      sel1       <= 2'd0;
      sel2       <= 2'd0;
      chk_valid  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      last_grant <= 2'd3;
      cnt        <= 4'd0;
    end else begin
      sel2      <= sel1;
      chk_valid <= en_o;
      if (chk_valid && !loop_in) begin
        err <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (win_ok) begin
            state      <= GRANT;
            grant      <= 4'b0001 << win;
            sel1       <= dst[{win, 1'b0} +: 2];
            en_o       <= 1'b1;
            busy       <= 1'b1;
            cnt        <= 4'd0;
            last_grant <= win;
          end
        end
        GRANT: begin
          // last_grant doubles as the current owner index.
          if (!req[last_grant] || cnt == CNT_LAST) begin
            state <= GAP;
            grant <= 4'b0000;
            en_o  <= 1'b0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        GAP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          grant <= 4'b0000;
          en_o  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chan_rr_sched.sv
// tb_chan_rr_sched: random and directed checks of chan_rr_sched
// against a behavioural channel-ownership model.
module tb_chan_rr_sched;

  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'h0;
  logic [7:0] dst = 8'h00;
  logic       loop_in = 1'b1;
  logic [3:0] grant;
  logic       en_o;
  logic [1:0] sel1;
  logic [1:0] sel2;
  logic       chk_valid;
  logic       busy;
  logic       err;

  int checks = 0;
  int failures = 0;

  chan_rr_sched #(.MAX_BURST(MB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .dst(dst),
    .loop_in(loop_in),
    .grant(grant),
    .en_o(en_o),
    .sel1(sel1),
    .sel2(sel2),
    .chk_valid(chk_valid),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  // model: phase 0 = nobody owns, 1 = owning, 2 = mandatory gap
  int         m_phase = 0;
  int         m_owner = 0;
  int         m_used = 0;
  int         m_last = 3;
  logic [3:0] e_grant = 0;
  logic       e_en = 0;
  logic [1:0] e_sel1 = 0;
  logic [1:0] e_sel2 = 0;
  logic       e_chk = 0;
  logic       e_busy = 0;
  logic       e_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic       n_err;
    logic [1:0] n_sel2;
    logic       n_chk;
    if (!rst_n) begin
      m_phase = 0; m_owner = 0; m_used = 0; m_last = 3;
      e_grant = 0; e_en = 0; e_sel1 = 0; e_sel2 = 0;
      e_chk = 0; e_busy = 0; e_err = 0;
      return;
    end
    n_err  = e_err | (e_chk & ~loop_in);
    n_sel2 = e_sel1;
    n_chk  = e_en;
    if (m_phase == 0) begin
      if (req != 0) begin
        for (int k = 1; k <= 4; k++) begin
          int i;
          i = (m_last + k) % 4;
          if (m_phase == 0 && req[i]) begin
            m_phase = 1; m_owner = i; m_last = i; m_used = 1;
            e_grant = 4'(1 << i);
            e_sel1 = dst[2*i +: 2];
            e_en = 1; e_busy = 1;
          end
        end
      end
    end else if (m_phase == 1) begin
      if (!req[m_owner] || m_used == MB) begin
        m_phase = 2; e_grant = 0; e_en = 0;
      end else begin
        m_used++;
      end
    end else begin
      m_phase = 0; e_busy = 0;
    end
    e_err = n_err; e_sel2 = n_sel2; e_chk = n_chk;
  endtask

  task automatic compare_all();
    chk("grant", grant, e_grant);
    chk("en_o", en_o, e_en);
    chk("sel1", sel1, e_sel1);
    chk("sel2", sel2, e_sel2);
    chk("chk_valid", chk_valid, e_chk);
    chk("busy", busy, e_busy);
    chk("err", err, e_err);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    req = 0;
    while (m_phase != 0 && n < 20) begin
      cycle();
      n++;
    end
    if (m_phase != 0) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    int n;
    @(negedge clk);
    rst_n = 0; req = 4'hF; dst = 8'hE4; loop_in = 1;
    cycle();
    cycle();
    chk("rst_grant", grant, 4'b0000);
    rst_n = 1;
    cycle();
    chk("rel_grant", grant, 4'b0001);
    chk("rel_sel1", sel1, 2'd0);
    repeat (30) cycle();

    // early release, dst stability, wrap-around arbitration
    wait_idle();
    dst = 8'h24; req = 4'b0100;
    cycle();
    chk("er_grant", grant, 4'b0100);
    chk("er_sel1", sel1, 2'd2);
    dst = 8'h14;
    cycle();
    chk("er_en2", en_o, 1'b1);
    chk("er_hold", sel1, 2'd2);
    req = 4'b0000;
    cycle();
    chk("er_gap_en", en_o, 1'b0);
    chk("er_gap_busy", busy, 1'b1);
    cycle();
    chk("er_idle", busy, 1'b0);
    req = 4'b1001;
    cycle();
    chk("wrap_grant", grant, 4'b1000);

    // random traffic with a clean loop
    for (int c = 0; c < 300; c++) begin
      req = 4'($urandom);
      if ($urandom_range(0, 3) == 0) req = 4'hF;
      dst = 8'($urandom);
      loop_in = 1;
      cycle();
    end

    // readback error: sticky until reset
    rst_n = 0; cycle(); rst_n = 1;
    req = 4'h1; loop_in = 1;
    cycle();
    cycle();
    loop_in = 0;
    cycle();
    chk("err_set", err, 1'b1);
    loop_in = 1; req = 4'hF;
    repeat (20) cycle();
    chk("err_sticky", err, 1'b1);
    rst_n = 0; cycle(); rst_n = 1;
    chk("err_clr", err, 1'b0);

    // reset on the 2nd GRANT cycle
    req = 4'hF;
    n = 0;
    while (!(m_phase == 1 && m_used == 2) && n < 20) begin
      cycle();
      n++;
    end
    if (!(m_phase == 1 && m_used == 2)) chk("mid_timeout", 0, 1);
    rst_n = 0;
    cycle();
    chk("mid_grant", grant, 4'b0000);
    chk("mid_busy", busy, 1'b0);
    rst_n = 1; req = 4'h1;
    cycle();
    chk("mid_regrant", grant, 4'b0001);

    // random traffic with noisy readback
    for (int c = 0; c < 200; c++) begin
      req = 4'($urandom);
      dst = 8'($urandom);
      loop_in = ($urandom_range(0, 9) != 0);
      rst_n = ($urandom_range(0, 49) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
